// File: rtl/spi_pkg.sv
// Shared types for the SPI burst sequencer: FSM state encoding and the latched burst command.
package spi_pkg;

  localparam int CS_MAX_W = 3;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_ISSUE    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_CS_HOLD  = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0]          len;
    logic [CS_MAX_W-1:0] cs;
    logic                keep;
  } burst_cmd_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO with occupancy counter; reads are combinational from the head entry.
module spi_sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  localparam int PTR_W     = $clog2(DEPTH),
  localparam int LVL_W     = PTR_W + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic [LVL_W-1:0]      level
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [LVL_W-1:0]      level_r;
  logic                  push_ok_s;
  logic                  pop_ok_s;

  // A push while full is dropped even if a pop frees a slot in the same cycle.
  assign full      = (level_r == LVL_W'(DEPTH));
  assign empty     = (level_r == LVL_W'(0));
  assign level     = level_r;
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign rd_data   = empty ? {DATA_WIDTH{1'b0}} : mem_r[rd_ptr_r];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      level_r  <= LVL_W'(0);
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   level_r <= level_r + LVL_W'(1);
        2'b01:   level_r <= level_r - LVL_W'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Storage array write port.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

endmodule

// File: rtl/spi_burst_sequencer.sv
// Burst sequencer in front of the SPI engine: TX/RX buffering, word-by-word issue and
// chip-select framing with programmable setup/hold.
module spi_burst_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int FIFO_DEPTH      = 8,
  parameter int NUM_CS          = 4,
  parameter int CS_SETUP_CYCLES = 2,
  parameter int CS_HOLD_CYCLES  = 2,
  localparam int CS_IDX_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int LVL_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [7:0]            cmd_len_i,
  input  logic [CS_IDX_W-1:0]   cmd_cs_i,
  input  logic                  cmd_keep_cs_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o,
  input  logic                  rd_ready_i,
  output logic [DATA_WIDTH-1:0] eng_tx_data_o,
  output logic                  eng_tx_valid_o,
  input  logic                  eng_tx_ready_i,
  input  logic [DATA_WIDTH-1:0] eng_rx_data_i,
  input  logic                  eng_rx_valid_i,
  output logic [NUM_CS-1:0]     cs_n_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [LVL_W-1:0]      tx_level_o,
  output logic [LVL_W-1:0]      rx_level_o
);

  state_t              state_r, state_s;
  burst_cmd_t          cmd_r, cmd_s;
  logic [7:0]          rem_r, rem_s;
  logic [CNT_W-1:0]    cnt_r, cnt_s;
  logic                held_r, held_s;
  logic [CS_MAX_W-1:0] held_cs_r, held_cs_s;
  logic                switch_r, switch_s;
  logic                done_r, done_s;
  logic                busy_r;
  logic [NUM_CS-1:0]   cs_n_r, cs_n_s;
  logic                cs_on_s;
  logic [CS_MAX_W-1:0] cs_idx_s;
  logic                tx_pop_s, rx_push_s;
  logic                tx_empty_s, tx_full_s, rx_empty_s, rx_full_s;

  spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (wr_valid_i),
    .pop     (tx_pop_s),
    .wr_data (wr_data_i),
    .rd_data (eng_tx_data_o),
    .full    (tx_full_s),
    .empty   (tx_empty_s),
    .level   (tx_level_o)
  );

  spi_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push    (rx_push_s),
    .pop     (rd_ready_i),
    .wr_data (eng_rx_data_i),
    .rd_data (rd_data_o),
    .full    (rx_full_s),
    .empty   (rx_empty_s),
    .level   (rx_level_o)
  );

  // Only one word is ever in flight, so a free RX slot at issue time guarantees no overflow.
  assign eng_tx_valid_o = (state_r == ST_ISSUE) & ~tx_empty_s & ~rx_full_s;
  assign cmd_ready_o    = (state_r == ST_IDLE);
  assign wr_ready_o     = ~tx_full_s;
  assign rd_valid_o     = ~rx_empty_s;
  assign cs_n_o         = cs_n_r;
  assign busy_o         = busy_r;
  assign done_o         = done_r;

  // Next-state, counters and FIFO strobes.
  always_comb begin
    state_s   = state_r;
    cmd_s     = cmd_r;
    rem_s     = rem_r;
    cnt_s     = cnt_r;
    held_s    = held_r;
    held_cs_s = held_cs_r;
    switch_s  = switch_r;
    done_s    = 1'b0;
    tx_pop_s  = 1'b0;
    rx_push_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          cmd_s.len  = cmd_len_i;
          cmd_s.cs   = CS_MAX_W'(cmd_cs_i);
          cmd_s.keep = cmd_keep_cs_i;
          rem_s      = cmd_len_i;
          cnt_s      = CNT_W'(0);
          if (held_r && (held_cs_r == CS_MAX_W'(cmd_cs_i))) begin
            held_s  = 1'b0;
            state_s = ST_ISSUE;
          end else if (held_r) begin
            switch_s = 1'b1;
            state_s  = ST_CS_HOLD;
          end else begin
            state_s = (CS_SETUP_CYCLES == 0) ? ST_ISSUE : ST_CS_SETUP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CS_SETUP: begin
        if (cnt_r == CNT_W'(CS_SETUP_CYCLES - 1)) begin
          cnt_s   = CNT_W'(0);
          state_s = ST_ISSUE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_ISSUE: begin
        if (eng_tx_valid_o && eng_tx_ready_i) begin
          tx_pop_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (eng_rx_valid_i) begin
          rx_push_s = 1'b1;
          if (rem_r != 8'd0) begin
            rem_s   = rem_r - 8'd1;
            state_s = ST_ISSUE;
          end else if (cmd_r.keep) begin
            held_s    = 1'b1;
            held_cs_s = cmd_r.cs;
            done_s    = 1'b1;
            state_s   = ST_IDLE;
          end else if (CS_HOLD_CYCLES == 0) begin
            done_s  = 1'b1;
            state_s = ST_IDLE;
          end else begin
            cnt_s    = CNT_W'(0);
            switch_s = 1'b0;
            state_s  = ST_CS_HOLD;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_CS_HOLD: begin
        // An index switch spends one extra cycle here with all selects released.
        if (switch_r && (cnt_r == CNT_W'(CS_HOLD_CYCLES))) begin
          held_s   = 1'b0;
          switch_s = 1'b0;
          cnt_s    = CNT_W'(0);
          state_s  = (CS_SETUP_CYCLES == 0) ? ST_ISSUE : ST_CS_SETUP;
        end else if (!switch_r && (cnt_r == CNT_W'(CS_HOLD_CYCLES - 1))) begin
          cnt_s   = CNT_W'(0);
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Chip-select decode from the next state so cs_n_o comes straight from a flop.
  always_comb begin
    cs_on_s  = 1'b0;
    cs_idx_s = cmd_s.cs;
    cs_n_s   = {NUM_CS{1'b1}};
    if ((state_s == ST_CS_HOLD) && switch_s) begin
      cs_on_s  = (cnt_s < CNT_W'(CS_HOLD_CYCLES));
      cs_idx_s = held_cs_s;
    end else if (state_s != ST_IDLE) begin
      cs_on_s = 1'b1;
    end else if (held_s) begin
      cs_on_s  = 1'b1;
      cs_idx_s = held_cs_s;
    end else begin
      cs_on_s = 1'b0;
    end
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_on_s && (cs_idx_s == CS_MAX_W'(i))) begin
        cs_n_s[i] = 1'b0;
      end else begin
        cs_n_s[i] = 1'b1;
      end
    end
  end

  // State and registered output update.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r   <= ST_IDLE;
      cmd_r     <= '{len: 8'd0, cs: CS_MAX_W'(0), keep: 1'b0};
      rem_r     <= 8'd0;
      cnt_r     <= CNT_W'(0);
      held_r    <= 1'b0;
      held_cs_r <= CS_MAX_W'(0);
      switch_r  <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      cs_n_r    <= {NUM_CS{1'b1}};
    end else begin
      state_r   <= state_s;
      cmd_r     <= cmd_s;
      rem_r     <= rem_s;
      cnt_r     <= cnt_s;
      held_r    <= held_s;
      held_cs_r <= held_cs_s;
      switch_r  <= switch_s;
      done_r    <= done_s;
      busy_r    <= (state_s != ST_IDLE) | held_s;
      cs_n_r    <= cs_n_s;
    end
  end

endmodule

// File: tb/tb_spi_burst_sequencer.sv
// Directed bench for spi_burst_sequencer with an echoing engine model (rx = tx ^ 0xFF).
module tb_spi_burst_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_len = 8'd0;
  logic [1:0] cmd_cs = 2'd0;
  logic       cmd_keep = 1'b0;
  logic [7:0] wr_data = 8'd0;
  logic       wr_valid = 1'b0;
  logic       rd_ready = 1'b0;
  logic       eng_tx_ready = 1'b1;
  logic [7:0] eng_rx_data;
  logic       eng_rx_valid;

  logic       cmd_ready_o, wr_ready_o, rd_valid_o, eng_tx_valid_o, busy_o, done_o;
  logic [7:0] rd_data_o, eng_tx_data_o;
  logic [3:0] cs_n_o, tx_level_o, rx_level_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0, done_cnt = 0, last_rx_cyc = 0, rise_cyc = 0, done_cyc = 0;
  int rise2_cyc = 0, fall0_cyc = 0, bad_cs = 0, multi_cs = 0, low_gap = 0;
  logic       chk_cs_en = 1'b0, watch_low = 1'b0;
  logic [3:0] cs_expect = 4'hF, prev_cs = 4'hF;
  logic [7:0] resp_d;

  always #5 clk = ~clk;

  spi_burst_sequencer #(
    .DATA_WIDTH(8), .FIFO_DEPTH(8), .NUM_CS(4), .CS_SETUP_CYCLES(2), .CS_HOLD_CYCLES(2)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_len_i(cmd_len),
    .cmd_cs_i(cmd_cs), .cmd_keep_cs_i(cmd_keep),
    .wr_data_i(wr_data), .wr_valid_i(wr_valid), .wr_ready_o(wr_ready_o),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready),
    .eng_tx_data_o(eng_tx_data_o), .eng_tx_valid_o(eng_tx_valid_o), .eng_tx_ready_i(eng_tx_ready),
    .eng_rx_data_i(eng_rx_data), .eng_rx_valid_i(eng_rx_valid),
    .cs_n_o(cs_n_o), .busy_o(busy_o), .done_o(done_o),
    .tx_level_o(tx_level_o), .rx_level_o(rx_level_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [7:0] d);
    wr_data  = d;
    wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic [7:0] len, input logic [1:0] cs, input logic keep);
    cmd_len   = len;
    cmd_cs    = cs;
    cmd_keep  = keep;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !cmd_ready_o; i++) tick();
    check("cmd_ready_wait", cmd_ready_o, 1);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target);
    for (int i = 0; i < 400; i++) begin
      if (done_cnt >= target) break;
      tick();
    end
    check(tag, done_cnt, target);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check(tag, {rd_valid_o, rd_data_o}, {1'b1, exp});
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine model: accept a word, answer two edges later with a 1-cycle rx pulse.
  initial begin
    eng_rx_valid = 1'b0;
    eng_rx_data  = 8'h00;
    forever begin
      @(negedge clk);
      if (eng_tx_valid_o && eng_tx_ready && !reset) begin
        resp_d = eng_tx_data_o;
        @(posedge clk);
        @(posedge clk);
        #1;
        eng_rx_data  = resp_d ^ 8'hFF;
        eng_rx_valid = 1'b1;
        @(posedge clk);
        #1;
        eng_rx_valid = 1'b0;
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (done_o) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (eng_rx_valid) last_rx_cyc = cyc;
    if (prev_cs != 4'hF && cs_n_o == 4'hF) rise_cyc = cyc;
    if (!prev_cs[2] && cs_n_o[2]) rise2_cyc = cyc;
    if (prev_cs[0] && !cs_n_o[0]) fall0_cyc = cyc;
    if ($countones(~cs_n_o) > 1) multi_cs++;
    if (chk_cs_en && cs_n_o != 4'hF && cs_n_o != cs_expect) bad_cs++;
    if (watch_low && cs_n_o[2]) low_gap++;
    prev_cs = cs_n_o;
  end

  initial begin
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_cmd_ready", cmd_ready_o, 1);
    check("rst_wr_ready", wr_ready_o, 1);
    check("rst_rd_valid", rd_valid_o, 0);
    check("rst_tx_valid", eng_tx_valid_o, 0);
    check("rst_cs_n", cs_n_o, 4'hF);
    check("rst_busy_done", {busy_o, done_o}, 2'b00);
    check("rst_levels", {tx_level_o, rx_level_o}, 8'h00);
    check("rst_data", {rd_data_o, eng_tx_data_o}, 16'h0000);

    // Basic 4-word burst on cs 1
    for (int i = 0; i < 4; i++) push_word(8'hA1 + 8'(i));
    check("t1_tx_level", tx_level_o, 4);
    check("t1_tx_head", eng_tx_data_o, 8'hA1);
    cs_expect = 4'b1101;
    chk_cs_en = 1'b1;
    done_cnt  = 0;
    send_cmd(8'd3, 2'd1, 1'b0);
    check("t1_setup_cs", cs_n_o, 4'b1101);
    check("t1_setup_c1", {busy_o, eng_tx_valid_o}, 2'b10);
    tick();
    check("t1_setup_c2", eng_tx_valid_o, 0);
    tick();
    check("t1_issue", {eng_tx_valid_o, eng_tx_data_o}, {1'b1, 8'hA1});
    wait_done("t1_done", 1);
    repeat (6) tick();
    chk_cs_en = 1'b0;
    check("t1_one_done", done_cnt, 1);
    check("t1_cs_released", cs_n_o, 4'hF);
    check("t1_bad_cs", bad_cs, 0);
    check("t1_hold_rise", rise_cyc - last_rx_cyc, 3);
    check("t1_done_time", done_cyc - last_rx_cyc, 3);
    check("t1_rx_level", rx_level_o, 4);
    pop_check("t1_rd0", 8'h5E);
    pop_check("t1_rd1", 8'h5D);
    pop_check("t1_rd2", 8'h5C);
    pop_check("t1_rd3", 8'h5B);
    check("t1_rx_empty", {rd_valid_o, rx_level_o}, 5'h00);

    // Command with empty TX FIFO stalls with CS asserted
    done_cnt = 0;
    send_cmd(8'd1, 2'd3, 1'b0);
    repeat (5) tick();
    check("t2_stall_cs", cs_n_o, 4'b0111);
    check("t2_stall_valid", {busy_o, eng_tx_valid_o}, 2'b10);
    push_word(8'h11);
    push_word(8'h22);
    wait_done("t2_done", 1);
    check("t2_hold_rise", rise_cyc - last_rx_cyc, 3);
    tick();
    pop_check("t2_rd0", 8'hEE);
    pop_check("t2_rd1", 8'hDD);

    // RX FIFO full blocks issue until the host pops
    for (int i = 0; i < 8; i++) push_word(8'h30 + 8'(i));
    done_cnt = 0;
    send_cmd(8'd7, 2'd0, 1'b0);
    wait_done("t3_fill_done", 1);
    check("t3_rx_full", rx_level_o, 8);
    push_word(8'h40);
    done_cnt = 0;
    send_cmd(8'd0, 2'd0, 1'b0);
    repeat (6) tick();
    check("t3_blocked", {cs_n_o, eng_tx_valid_o}, {4'b1110, 1'b0});
    check("t3_tx_pending", tx_level_o, 1);
    pop_check("t3_rd0", 8'hCF);
    check("t3_unblocked", eng_tx_valid_o, 1);
    wait_done("t3_done", 1);
    check("t3_rx_level", rx_level_o, 8);
    for (int i = 1; i < 8; i++) pop_check("t3_rd", 8'hCF - 8'(i));
    pop_check("t3_rd_last", 8'hBF);

    // Keep-CS chaining and index switch
    for (int i = 0; i < 4; i++) push_word(8'h51 + 8'(i));
    done_cnt = 0;
    send_cmd(8'd0, 2'd2, 1'b1);
    wait_done("t4_keep_done", 1);
    tick();
    check("t4_held_cs", cs_n_o, 4'b1011);
    check("t4_held_busy", {busy_o, cmd_ready_o}, 2'b11);
    low_gap   = 0;
    watch_low = 1'b1;
    done_cnt  = 0;
    send_cmd(8'd0, 2'd2, 1'b0);
    check("t4_no_setup", eng_tx_valid_o, 1);
    repeat (3) tick();
    watch_low = 1'b0;
    check("t4_cs_stayed_low", low_gap, 0);
    wait_done("t4_same_done", 1);
    done_cnt = 0;
    send_cmd(8'd0, 2'd2, 1'b1);
    wait_done("t4_keep2_done", 1);
    rise2_cyc = 0;
    fall0_cyc = 0;
    done_cnt  = 0;
    send_cmd(8'd0, 2'd0, 1'b0);
    check("t4_switch_hold", cs_n_o, 4'b1011);
    wait_done("t4_switch_done", 1);
    repeat (8) tick();
    check("t4_switch_one_done", done_cnt, 1);
    check("t4_switch_gap", fall0_cyc - rise2_cyc, 1);
    check("t4_onehot", multi_cs, 0);
    pop_check("t4_rd0", 8'hAE);
    pop_check("t4_rd1", 8'hAD);
    pop_check("t4_rd2", 8'hAC);
    pop_check("t4_rd3", 8'hAB);

    // Reset in the middle of a burst
    for (int i = 0; i < 4; i++) push_word(8'h61 + 8'(i));
    send_cmd(8'd3, 2'd1, 1'b0);
    for (int i = 0; i < 100 && rx_level_o != 4'd1; i++) tick();
    check("t5_first_word", rx_level_o, 1);
    tick();
    tick();
    reset = 1'b1;
    #1;
    check("t5_cs_async", cs_n_o, 4'hF);
    check("t5_levels", {tx_level_o, rx_level_o}, 8'h00);
    check("t5_outputs", {busy_o, eng_tx_valid_o, rd_valid_o}, 3'b000);
    tick();
    reset = 1'b0;
    tick();
    check("t5_cmd_ready", cmd_ready_o, 1);
    repeat (6) tick();
    check("t5_still_idle", {tx_level_o, rx_level_o, cs_n_o}, 12'h00F);

    // Push into a full TX FIFO while the engine pops it
    eng_tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'h71 + 8'(i));
    check("t6_tx_full", {wr_ready_o, tx_level_o}, 5'h08);
    done_cnt = 0;
    send_cmd(8'd0, 2'd0, 1'b0);
    tick();
    tick();
    check("t6_issue", {eng_tx_valid_o, eng_tx_data_o}, {1'b1, 8'h71});
    wr_data      = 8'h99;
    wr_valid     = 1'b1;
    eng_tx_ready = 1'b1;
    check("t6_wr_ready", wr_ready_o, 0);
    tick();
    wr_valid = 1'b0;
    check("t6_level_dec", tx_level_o, 7);
    check("t6_new_head", eng_tx_data_o, 8'h72);
    wait_done("t6_done", 1);
    check("t6_surplus", tx_level_o, 7);
    pop_check("t6_rd0", 8'h8E);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
